ex_mem_reg: RTL and testbench

- Clocked EX→MEM pipeline register of the arith_muladd core.
- Captures EX results: GPR write, HI/LO write, and the multi-cycle madd/msub scratch state (cnt, hilo_tempt). Drives the combinational MEM stage.
- Return path: while EX is stalled mid-madd/msub, latches cnt/hilo_tempt and feeds them back to EX, so EX can finish the accumulate on the next cycle.
- Honours the ctrl stall vector and pipeline flush.

---
 rtl/ex_mem_reg.sv | 164 ++++++++++++++++
 tb/tb_ex_mem_reg.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with madd/msub scratch feedback to EX.
// Optional EXMEM_PERF_EN adds a saturating 16-bit count of bubbles inserted while EX is stalled.
module ex_mem_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned CNT_W  = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [5:0]          stall,
    input  logic                flush,
    input  logic                ex_we,
    input  logic [AW-1:0]       ex_waddr,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [CNT_W-1:0]    ex_cnt,
    input  logic [2*DATA_W-1:0] ex_hilo_tempt,
    output logic                em_we,
    output logic [AW-1:0]       em_waddr,
    output logic [DATA_W-1:0]   em_wdata,
    output logic                em_whilo,
    output logic [DATA_W-1:0]   em_hi,
    output logic [DATA_W-1:0]   em_lo,
    output logic [CNT_W-1:0]    em_cnt,
    output logic [2*DATA_W-1:0] em_hilo_tempt,
    output logic [CNT_W-1:0]    fb_cnt,
    output logic [2*DATA_W-1:0] fb_hilo_tempt
`ifdef EXMEM_PERF_EN
    ,
    output logic [15:0]         bubble_cnt
`endif
);

    logic                we_q, we_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                whilo_q, whilo_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] tempt_q, tempt_d;
    logic [CNT_W-1:0]    fb_cnt_q, fb_cnt_d;
    logic [2*DATA_W-1:0] fb_tempt_q, fb_tempt_d;

    logic ex_bubble;
    logic ex_advance;

    // Only the EX and MEM stall bits matter to this stage.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    // EX stalled with MEM running inserts a bubble; MEM stalled (legal or not) holds everything.
    assign ex_bubble  = !flush && stall[3] && !stall[4];
    assign ex_advance = !flush && !stall[3] && !stall[4];

    always_comb begin
        we_d       = we_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        whilo_d    = whilo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        tempt_d    = tempt_q;
        fb_cnt_d   = fb_cnt_q;
        fb_tempt_d = fb_tempt_q;
        if (flush) begin
            we_d       = 1'b0;
            waddr_d    = '0;
            wdata_d    = '0;
            whilo_d    = 1'b0;
            hi_d       = '0;
            lo_d       = '0;
            cnt_d      = '0;
            tempt_d    = '0;
            fb_cnt_d   = '0;
            fb_tempt_d = '0;
        end else if (ex_bubble) begin
            we_d       = 1'b0;
            waddr_d    = '0;
            wdata_d    = '0;
            whilo_d    = 1'b0;
            hi_d       = '0;
            lo_d       = '0;
            cnt_d      = '0;
            tempt_d    = '0;
            fb_cnt_d   = ex_cnt;
            fb_tempt_d = ex_hilo_tempt;
        end else if (ex_advance) begin
            we_d       = ex_we;
            waddr_d    = ex_waddr;
            wdata_d    = ex_wdata;
            whilo_d    = ex_whilo;
            hi_d       = ex_hi;
            lo_d       = ex_lo;
            cnt_d      = ex_cnt;
            tempt_d    = ex_hilo_tempt;
            fb_cnt_d   = '0;
            fb_tempt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            whilo_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            tempt_q    <= '0;
            fb_cnt_q   <= '0;
            fb_tempt_q <= '0;
        end else begin
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            whilo_q    <= whilo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            tempt_q    <= tempt_d;
            fb_cnt_q   <= fb_cnt_d;
            fb_tempt_q <= fb_tempt_d;
        end
    end

    assign em_we         = we_q;
    assign em_waddr      = waddr_q;
    assign em_wdata      = wdata_q;
    assign em_whilo      = whilo_q;
    assign em_hi         = hi_q;
    assign em_lo         = lo_q;
    assign em_cnt        = cnt_q;
    assign em_hilo_tempt = tempt_q;
    assign fb_cnt        = fb_cnt_q;
    assign fb_hilo_tempt = fb_tempt_q;

`ifdef EXMEM_PERF_EN
    logic [15:0] bubble_q, bubble_d;

    // Flush does not clear the counter; only reset does.
    always_comb begin
        bubble_d = bubble_q;
        if (ex_bubble && bubble_q != 16'hFFFF) begin
            bubble_d = bubble_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bubble_q <= '0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: expected outputs are queued as each edge's stimulus is driven.
// Define EXMEM_PERF_EN to also exercise the bubble counter.
module tb_ex_mem_reg;

    logic         clk;
    logic         reset_n;
    logic [5:0]   stall;
    logic         flush;
    logic         ex_we;
    logic [4:0]   ex_waddr;
    logic [31:0]  ex_wdata;
    logic         ex_whilo;
    logic [31:0]  ex_hi;
    logic [31:0]  ex_lo;
    logic [4:0]   ex_cnt;
    logic [63:0]  ex_hilo_tempt;
    logic         em_we;
    logic [4:0]   em_waddr;
    logic [31:0]  em_wdata;
    logic         em_whilo;
    logic [31:0]  em_hi;
    logic [31:0]  em_lo;
    logic [4:0]   em_cnt;
    logic [63:0]  em_hilo_tempt;
    logic [4:0]   fb_cnt;
    logic [63:0]  fb_hilo_tempt;
    logic [15:0]  bubble_cnt;

    int n_vec;
    int n_err;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [4:0]  cnt;
        logic [63:0] tempt;
        logic [4:0]  fcnt;
        logic [63:0] ftempt;
        logic [15:0] bub;
    } out_t;

    out_t model;
    out_t exp_q[$];

    ex_mem_reg dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .flush         (flush),
        .ex_we         (ex_we),
        .ex_waddr      (ex_waddr),
        .ex_wdata      (ex_wdata),
        .ex_whilo      (ex_whilo),
        .ex_hi         (ex_hi),
        .ex_lo         (ex_lo),
        .ex_cnt        (ex_cnt),
        .ex_hilo_tempt (ex_hilo_tempt),
        .em_we         (em_we),
        .em_waddr      (em_waddr),
        .em_wdata      (em_wdata),
        .em_whilo      (em_whilo),
        .em_hi         (em_hi),
        .em_lo         (em_lo),
        .em_cnt        (em_cnt),
        .em_hilo_tempt (em_hilo_tempt),
        .fb_cnt        (fb_cnt),
        .fb_hilo_tempt (fb_hilo_tempt)
`ifdef EXMEM_PERF_EN
        ,
        .bubble_cnt    (bubble_cnt)
`endif
    );

`ifndef EXMEM_PERF_EN
    assign bubble_cnt = 16'h0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour for one rising edge given the currently driven inputs.
    function automatic out_t model_next(input out_t c);
        out_t n;
        n = c;
        if (!reset_n) begin
            n = '0;
        end else if (flush) begin
            n = '0;
            n.bub = c.bub;
        end else if (stall[3] && !stall[4]) begin
            n = '0;
            n.fcnt   = ex_cnt;
            n.ftempt = ex_hilo_tempt;
            n.bub    = (c.bub == 16'hFFFF) ? c.bub : c.bub + 16'd1;
        end else if (!stall[3] && !stall[4]) begin
            n.we     = ex_we;
            n.waddr  = ex_waddr;
            n.wdata  = ex_wdata;
            n.whilo  = ex_whilo;
            n.hi     = ex_hi;
            n.lo     = ex_lo;
            n.cnt    = ex_cnt;
            n.tempt  = ex_hilo_tempt;
            n.fcnt   = '0;
            n.ftempt = '0;
        end
`ifndef EXMEM_PERF_EN
        n.bub = '0;
`endif
        return n;
    endfunction

    task automatic compare_out(input string tag);
        out_t e;
        if (exp_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        check_val({tag, "_we"},     {63'd0, em_we},     {63'd0, e.we});
        check_val({tag, "_waddr"},  {59'd0, em_waddr},  {59'd0, e.waddr});
        check_val({tag, "_wdata"},  {32'd0, em_wdata},  {32'd0, e.wdata});
        check_val({tag, "_whilo"},  {63'd0, em_whilo},  {63'd0, e.whilo});
        check_val({tag, "_hi"},     {32'd0, em_hi},     {32'd0, e.hi});
        check_val({tag, "_lo"},     {32'd0, em_lo},     {32'd0, e.lo});
        check_val({tag, "_cnt"},    {59'd0, em_cnt},    {59'd0, e.cnt});
        check_val({tag, "_tempt"},  em_hilo_tempt,      e.tempt);
        check_val({tag, "_fbcnt"},  {59'd0, fb_cnt},    {59'd0, e.fcnt});
        check_val({tag, "_fbtmpt"}, fb_hilo_tempt,      e.ftempt);
`ifdef EXMEM_PERF_EN
        check_val({tag, "_bubble"}, {48'd0, bubble_cnt}, {48'd0, e.bub});
`endif
    endtask

    // Inputs are set at the falling edge; this pushes the expectation, clocks, and compares.
    task automatic step(input string tag);
        out_t n;
        n = model_next(model);
        exp_q.push_back(n);
        model = n;
        @(posedge clk);
        #1;
        compare_out(tag);
        @(negedge clk);
    endtask

    task automatic set_ex(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic wh, input logic [31:0] hi, input logic [31:0] lo,
                          input logic [4:0] cnt, input logic [63:0] tmp);
        ex_we = we; ex_waddr = wa; ex_wdata = wd; ex_whilo = wh;
        ex_hi = hi; ex_lo = lo; ex_cnt = cnt; ex_hilo_tempt = tmp;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model = '0;
        reset_n = 1'b0;
        stall = 6'b001111;
        flush = 1'b0;
        set_ex(1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 32'h1, 32'h2, 5'd9, 64'hFFFF_0000_1234_5678);
        @(negedge clk);

        // Reset wins over a case-3 stall with nonzero scratch.
        step("reset0");
        step("reset1");
        check_val("reset_wdata", {32'd0, em_wdata}, 64'd0);
        reset_n = 1'b1;
        stall = 6'b000000;
        step("load_pre_pulse");
        // Reset is synchronous: a pulse between edges leaves outputs alone.
        reset_n = 1'b0;
        #2;
        exp_q.push_back(model);
        compare_out("async_pulse");
        reset_n = 1'b1;
        @(negedge clk);

        set_ex(1'b1, 5'd7, 32'h12345678, 1'b1, 32'hA, 32'hB, 5'd0, 64'd0);
        step("pass");
        check_val("pass_wdata", {32'd0, em_wdata}, 64'h12345678);

        // Two-cycle madd: EX stalls once, then finishes using the fed-back scratch.
        stall = 6'b001111;
        set_ex(1'b1, 5'd2, 32'h77, 1'b1, 32'h3, 32'h4, 5'd1, 64'h0000_0001_0000_0002);
        step("madd1");
        check_val("madd1_fbtmpt", fb_hilo_tempt, 64'h0000_0001_0000_0002);
        stall = 6'b000000;
        set_ex(1'b0, 5'd0, 32'h0, 1'b1, 32'h5, 32'h6, 5'd2, 64'h0000_0001_0000_0008);
        step("madd2");
        check_val("madd2_fbcnt", {59'd0, fb_cnt}, 64'd0);

        // Full hold and the illegal MEM-only stall.
        set_ex(1'b1, 5'd4, 32'h55, 1'b0, 32'h0, 32'h0, 5'd0, 64'd0);
        step("hold_load");
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            ex_wdata = $urandom;
            ex_cnt   = 5'($urandom);
            step("hold");
        end
        check_val("hold_wdata", {32'd0, em_wdata}, 64'h55);
        stall = 6'b010000;
        ex_wdata = 32'hCAFE;
        step("illegal_hold");
        check_val("illegal_wdata", {32'd0, em_wdata}, 64'h55);

        // Back-to-back case-3 edges track the latest scratch.
        stall = 6'b001000;
        ex_cnt = 5'd1; ex_hilo_tempt = 64'h11;
        step("b2b1");
        ex_cnt = 5'd2; ex_hilo_tempt = 64'h22;
        step("b2b2");
        // Flush outranks the EX stall.
        stall = 6'b001111;
        flush = 1'b1;
        step("flush");
        check_val("flush_fbcnt", {59'd0, fb_cnt}, 64'd0);
        flush = 1'b0;

        // Randomised mix including ignored stall bits.
        for (int i = 0; i < 300; i++) begin
            reset_n = ($urandom_range(0, 31) != 0);
            flush   = ($urandom_range(0, 15) == 0);
            stall   = 6'($urandom);
            set_ex(1'($urandom), 5'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
                   5'($urandom), {$urandom, $urandom});
            step("rand");
        end
        reset_n = 1'b1;
        flush = 1'b0;

`ifdef EXMEM_PERF_EN
        reset_n = 1'b0;
        step("perf_rst");
        reset_n = 1'b1;
        stall = 6'b001000;
        for (int i = 0; i < 3; i++) step("perf_bub");
        check_val("perf_three", {48'd0, bubble_cnt}, 64'd3);
        flush = 1'b1;
        step("perf_flush");
        check_val("perf_flush_keep", {48'd0, bubble_cnt}, 64'd3);
        flush = 1'b0;
        reset_n = 1'b0;
        step("perf_rst2");
        check_val("perf_rst_zero", {48'd0, bubble_cnt}, 64'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            model = model_next(model);
            @(posedge clk);
            @(negedge clk);
        end
        check_val("perf_sat", {48'd0, bubble_cnt}, 64'hFFFF);
        step("perf_sat_hold");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
